// File: rtl/rfphoenix_dcache_tag_lookup_pkg.sv
// Shared constants and types for the rfPhoenix dcache tag store.
// Holds the cache geometry, the maintenance state enum and the victim-LFSR step.
package rfphoenix_dcache_tag_lookup_pkg;
  localparam int DC_AWID  = 32;
  localparam int DC_LOBIT = 6;
  localparam int DC_SETS  = 64;
  localparam int DC_IDXW  = $clog2(DC_SETS);
  localparam int DC_TAGW  = DC_AWID - DC_LOBIT - DC_IDXW;
  localparam int DC_WAYS  = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, SWEEP, INV_RD, INV_WR} dcache_tag_state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/rfphoenix_dcache_tag_lookup_if.sv
// Lookup / fill / maintenance bus between the way-select stage and the tag store.
interface rfphoenix_dcache_tag_lookup_if #(parameter int AWID = 32);
  logic            req;
  logic [AWID-1:0] adr;
  logic            hit_v;
  logic            hit;
  logic [1:0]      rway;
  logic [1:0]      lfsr;
  logic            wr_dc;
  logic [AWID-1:0] wadr;
  logic [1:0]      wway;
  logic            inv_line;
  logic [AWID-1:0] inv_adr;
  logic            inv_all;
  logic            busy;

  modport master (output req, adr, wr_dc, wadr, wway, inv_line, inv_adr, inv_all,
                  input  hit_v, hit, rway, lfsr, busy);
  modport slave  (input  req, adr, wr_dc, wadr, wway, inv_line, inv_adr, inv_all,
                  output hit_v, hit, rway, lfsr, busy);
endinterface

// File: rtl/rfphoenix_dcache_tag_ram.sv
// One way of the dcache tag array: synchronous read-first read port plus a write port.
module rfphoenix_dcache_tag_ram #(
  parameter int SETS = 64,
  parameter int W    = 20
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [$clog2(SETS)-1:0] i_waddr,
  input  logic [W-1:0]            i_wdata,
  input  logic [$clog2(SETS)-1:0] i_raddr,
  output logic [W-1:0]            o_rdata
);
  logic [W-1:0] r_mem [SETS];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/rfphoenix_dcache_tag_lookup.sv
// Tag store, hit detector and victim-way source for the rfPhoenix 4-way dcache.
// Also owns valid-bit maintenance: reset sweep, invalidate-all, single-line invalidate.
module rfphoenix_dcache_tag_lookup
  import rfphoenix_dcache_tag_lookup_pkg::*;
#(
  parameter int AWID  = DC_AWID,
  parameter int LOBIT = DC_LOBIT,
  parameter int SETS  = DC_SETS
) (
  input logic                          clk,
  input logic                          rst,
  rfphoenix_dcache_tag_lookup_if.slave bus
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = AWID - LOBIT - IDXW;

  dcache_tag_state_t            r_state;
  logic [IDXW-1:0]              r_cnt, r_inv_idx, r_ridx;
  logic [TAGW-1:0]              r_inv_tag, r_lk_tag, r_wtag;
  logic [SETS-1:0][DC_WAYS-1:0] r_valid;
  logic [DC_WAYS-1:0]           r_byp;
  logic                         r_hit_v;
  logic [15:0]                  r_lfsr;
  logic [1:0]                   r_vict;

  logic [IDXW-1:0]              w_lk_idx, w_widx, w_ii_idx, w_raddr;
  logic [TAGW-1:0]              w_lk_tag, w_wtag, w_ii_tag, w_cmp_tag;
  logic [DC_WAYS-1:0][TAGW-1:0] w_rtag, w_tag_eff;
  logic [DC_WAYS-1:0]           w_vset, w_match;
  logic [1:0]                   w_rway, w_vict;
  logic                         w_acc, w_fill;
  logic                         w_unused;

  assign w_lk_idx = bus.adr[LOBIT+IDXW-1:LOBIT];
  assign w_lk_tag = bus.adr[AWID-1:LOBIT+IDXW];
  assign w_widx   = bus.wadr[LOBIT+IDXW-1:LOBIT];
  assign w_wtag   = bus.wadr[AWID-1:LOBIT+IDXW];
  assign w_ii_idx = bus.inv_adr[LOBIT+IDXW-1:LOBIT];
  assign w_ii_tag = bus.inv_adr[AWID-1:LOBIT+IDXW];
  assign w_unused = ^{bus.adr[LOBIT-1:0], bus.wadr[LOBIT-1:0], bus.inv_adr[LOBIT-1:0]};

  assign w_acc  = bus.req && (r_state == IDLE) && !bus.inv_line && !bus.inv_all;
  assign w_fill = bus.wr_dc && (r_state != SWEEP);
  // Lookups are blocked while busy, so the invalidate index can own the read port then
  assign w_raddr = (r_state == IDLE) ? w_lk_idx : r_inv_idx;

  for (genvar g = 0; g < DC_WAYS; g++) begin : g_way
    rfphoenix_dcache_tag_ram #(.SETS(SETS), .W(TAGW)) u_ram (
      .clk     (clk),
      .i_we    (w_fill && (bus.wway == 2'(g))),
      .i_waddr (w_widx),
      .i_wdata (w_wtag),
      .i_raddr (w_raddr),
      .o_rdata (w_rtag[g])
    );
  end

  // A fill that lands on the set being read overrides the read-first RAM data
  always_ff @(posedge clk) begin
    r_ridx   <= w_raddr;
    r_lk_tag <= w_lk_tag;
    r_wtag   <= w_wtag;
    for (int w = 0; w < DC_WAYS; w++)
      r_byp[w] <= w_fill && (bus.wway == 2'(w)) && (w_widx == w_raddr);
  end

  assign w_vset    = r_valid[r_ridx];
  assign w_cmp_tag = (r_state == INV_WR) ? r_inv_tag : r_lk_tag;

  always_comb begin
    w_tag_eff = w_rtag;
    w_match   = '0;
    w_rway    = '0;
    w_vict    = r_lfsr[1:0];
    for (int w = 0; w < DC_WAYS; w++) begin
      if (r_byp[w]) w_tag_eff[w] = r_wtag;
      w_match[w] = w_vset[w] && (w_tag_eff[w] == w_cmp_tag);
    end
    for (int w = DC_WAYS-1; w >= 0; w--) begin
      if (w_match[w]) w_rway = 2'(w);
      if (!w_vset[w]) w_vict = 2'(w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SWEEP;
      r_cnt     <= '0;
      r_inv_idx <= '0;
      r_inv_tag <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.inv_all) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
          end else if (bus.inv_line) begin
            r_state   <= INV_RD;
            r_inv_idx <= w_ii_idx;
            r_inv_tag <= w_ii_tag;
          end
        end
        SWEEP: begin
          if (r_cnt == IDXW'(SETS-1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        INV_RD:  r_state <= INV_WR;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Valid bits are cleared by the sweep rather than by reset; a fill beats an INV_WR clear
  always_ff @(posedge clk) begin
    if (r_state == SWEEP) begin
      r_valid[r_cnt] <= '0;
    end else begin
      if (r_state == INV_WR)
        for (int w = 0; w < DC_WAYS; w++)
          if (w_match[w]) r_valid[r_inv_idx][w] <= 1'b0;
      if (w_fill) r_valid[w_widx][bus.wway] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_v <= 1'b0;
      r_lfsr  <= LFSR_SEED;
      r_vict  <= LFSR_SEED[1:0];
    end else begin
      r_hit_v <= w_acc;
      r_lfsr  <= lfsr_step(r_lfsr);
      if (r_hit_v) r_vict <= w_vict;
    end
  end

  assign bus.hit_v = r_hit_v;
  assign bus.hit   = r_hit_v && (|w_match);
  assign bus.rway  = bus.hit ? w_rway : 2'b00;
  assign bus.lfsr  = r_hit_v ? w_vict : r_vict;
  assign bus.busy  = (r_state != IDLE);
endmodule

// File: tb/tb_rfphoenix_dcache_tag_lookup.sv
// Directed bench for the dcache tag store: sweep, fill/hit, bypass, victim, invalidates, reset.
module tb_rfphoenix_dcache_tag_lookup;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  rfphoenix_dcache_tag_lookup_if #(.AWID(32)) bus ();

  rfphoenix_dcache_tag_lookup dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [15:0] m_step(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference victim LFSR, free-running from the seed whenever reset is low
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= m_step(m_lfsr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] a, input logic [1:0] w);
    bus.wr_dc = 1'b1; bus.wadr = a; bus.wway = w;
    tick();
    bus.wr_dc = 1'b0;
  endtask

  // el < 0 means the victim must come from the LFSR low bits
  task automatic look(input string tag, input logic [31:0] a, input logic eh,
                      input logic [1:0] er, input int el);
    logic [1:0] exp_l;
    bus.req = 1'b1; bus.adr = a;
    tick();
    bus.req = 1'b0;
    exp_l = (el < 0) ? m_lfsr[1:0] : 2'(el);
    chk({tag, ".hit_v"}, bus.hit_v, 1);
    chk({tag, ".hit"},   bus.hit,   eh);
    chk({tag, ".rway"},  bus.rway,  er);
    chk({tag, ".lfsr"},  bus.lfsr,  exp_l);
  endtask

  task automatic wait_idle(input string tag, input int exp);
    int n = 0;
    int hv = 0;
    while (bus.busy && n < 300) begin
      if (bus.hit_v) hv++;
      n++;
      tick();
    end
    chk({tag, ".busy_cycles"}, n, exp);
    chk({tag, ".no_hit_v"}, hv, 0);
  endtask

  initial begin
    logic [1:0] held;
    bus.req = 0; bus.adr = '0; bus.wr_dc = 0; bus.wadr = '0; bus.wway = '0;
    bus.inv_line = 0; bus.inv_adr = '0; bus.inv_all = 0;
    repeat (3) tick();
    chk("rst.hit_v", bus.hit_v, 0);
    chk("rst.hit",   bus.hit,   0);
    chk("rst.rway",  bus.rway,  0);
    chk("rst.lfsr",  bus.lfsr,  1);
    chk("rst.busy",  bus.busy,  1);

    // Reset sweep with req held high throughout
    bus.req = 1'b1; bus.adr = 32'h0000_1000;
    rst = 1'b0;
    wait_idle("sweep", 64);
    look("first", 32'h0000_1000, 0, 0, 0);

    fill(32'h0000_1040, 2);
    look("fillhit", 32'h0000_1044, 1, 2, 0);

    bus.wr_dc = 1'b1; bus.wadr = 32'h0000_A080; bus.wway = 3;
    look("bypass", 32'h0000_A080, 1, 3, 0);
    bus.wr_dc = 1'b0;
    look("miss", 32'h0000_B080, 0, 0, 0);

    // Full set 5: victim must come from the LFSR, then hold while hit_v is low
    fill(32'h0000_1140, 0); fill(32'h0000_2140, 1);
    fill(32'h0000_3140, 2); fill(32'h0000_4140, 3);
    look("full", 32'h0000_9140, 0, 0, -1);
    held = m_lfsr[1:0];
    tick();
    chk("hold.hit_v", bus.hit_v, 0);
    chk("hold.lfsr",  bus.lfsr,  held);
    look("fullhit", 32'h0000_3140, 1, 2, -1);

    fill(32'h0000_7180, 3); fill(32'h0000_7180, 1);
    look("multi", 32'h0000_7180, 1, 1, 0);

    // Single-line invalidate in set 0
    fill(32'h0000_3000, 0); fill(32'h0000_2000, 1);
    look("preinv", 32'h0000_2000, 1, 1, 2);
    bus.inv_line = 1'b1; bus.inv_adr = 32'h0000_2000;
    tick();
    bus.inv_line = 1'b0;
    wait_idle("inv", 2);
    look("inv.miss", 32'h0000_2000, 0, 0, 1);
    look("inv.keep", 32'h0000_3000, 1, 0, 1);

    fill(32'h0000_2000, 1);
    bus.inv_line = 1'b1;
    tick();
    bus.inv_line = 1'b0;
    chk("invrd.busy", bus.busy, 1);
    tick();
    chk("invwr.busy", bus.busy, 1);
    bus.wr_dc = 1'b1; bus.wadr = 32'h0000_2000; bus.wway = 1;
    tick();
    bus.wr_dc = 1'b0;
    chk("invdone.busy", bus.busy, 0);
    look("inv.fillwins", 32'h0000_2000, 1, 1, 2);

    // Invalidate all
    bus.inv_all = 1'b1;
    tick();
    bus.inv_all = 1'b0;
    wait_idle("invall", 64);
    look("ia.a", 32'h0000_1044, 0, 0, 0);
    look("ia.b", 32'h0000_A080, 0, 0, 0);
    look("ia.c", 32'h0000_3140, 0, 0, 0);
    look("ia.d", 32'h0000_2000, 0, 0, 0);

    // Reset at sweep cycle 20 restarts the sweep
    bus.inv_all = 1'b1;
    tick();
    bus.inv_all = 1'b0;
    repeat (20) tick();
    chk("midsweep.busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("midsweep.rst_lfsr", bus.lfsr, 1);
    tick();
    rst = 1'b0;
    wait_idle("rstsweep", 64);

    // In-flight hit_v is dropped by reset
    fill(32'h0000_5000, 0);
    bus.req = 1'b1; bus.adr = 32'h0000_5000;
    tick();
    bus.req = 1'b0;
    chk("inflight.hit", bus.hit, 1);
    rst = 1'b1;
    #1;
    chk("inflight.drop", bus.hit_v, 0);
    tick();
    rst = 1'b0;
    wait_idle("rst2", 64);
    look("post", 32'h0000_5000, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
